// File: rtl/flex_sample_cnt_pkg.sv
// Shared types for the flexible sample-window counter.
// Optional interrupt logic elsewhere is enabled by FLEX_SAMPLE_CNT_IRQ_EN.
package flex_sample_cnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsc_state_t;

endpackage

// File: rtl/flex_sample_counter_if.sv
// Control/status bundle between the sample-strobe source and flex_sample_counter.
// irq/irq_ack exist only when FLEX_SAMPLE_CNT_IRQ_EN is defined.
interface flex_sample_counter_if #(
  parameter int NUM_CNT_BITS = 10,
  parameter int NUM_WIN_BITS = 8
);

  logic                    clear;
  logic                    start;
  logic                    mode_cont;
  logic [NUM_CNT_BITS-1:0] rollover_val;
  logic                    cnt_up;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    window_done;
  logic [NUM_WIN_BITS-1:0] window_cnt;
  logic                    busy;
  logic                    cfg_err;
`ifdef FLEX_SAMPLE_CNT_IRQ_EN
  logic                    irq_ack;
  logic                    irq;
`endif

`ifdef FLEX_SAMPLE_CNT_IRQ_EN
  modport master (
    output clear, start, mode_cont, rollover_val, cnt_up, irq_ack,
    input  count_out, window_done, window_cnt, busy, cfg_err, irq
  );
  modport slave (
    input  clear, start, mode_cont, rollover_val, cnt_up, irq_ack,
    output count_out, window_done, window_cnt, busy, cfg_err, irq
  );
`else
  modport master (
    output clear, start, mode_cont, rollover_val, cnt_up,
    input  count_out, window_done, window_cnt, busy, cfg_err
  );
  modport slave (
    input  clear, start, mode_cont, rollover_val, cnt_up,
    output count_out, window_done, window_cnt, busy, cfg_err
  );
`endif

endinterface

// File: rtl/flex_counter.sv
// Generic up-counter with sync clear and programmable rollover (R wraps to 1).
// rollover_flag is registered and coincides with count_out == rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    rollover_next
);

  logic [NUM_CNT_BITS-1:0] next_count;

  // A full window restarts at 1, so the count never passes through 0 while wrapping.
  assign next_count    = (count_out == rollover_val) ? NUM_CNT_BITS'(1)
                                                     : count_out + NUM_CNT_BITS'(1);
  assign rollover_next = (next_count == rollover_val);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else if (clear) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else if (count_enable) begin
      count_out     <= next_count;
      rollover_flag <= rollover_next;
    end else begin
      rollover_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/flex_sample_counter.sv
// Sample-window counter: run-time window length, one-shot/continuous modes,
// saturating window count. FLEX_SAMPLE_CNT_IRQ_EN adds a sticky irq with ack.
module flex_sample_counter
  import flex_sample_cnt_pkg::*;
#(
  parameter int NUM_CNT_BITS = 10,
  parameter int NUM_WIN_BITS = 8
) (
  input logic                  clk,
  input logic                  rst,
  flex_sample_counter_if.slave bus
);

  fsc_state_t              state;
  logic [NUM_CNT_BITS-1:0] shadow_r;
  logic                    shadow_mode;
  logic [NUM_WIN_BITS-1:0] window_cnt;
  logic                    cfg_err;
  logic [NUM_CNT_BITS-1:0] count;
  logic                    window_done;
  logic                    rollover_next;
  logic                    start_ok;
  logic                    start_bad;
  logic                    cnt_clear;
  logic                    cnt_en;
  logic                    boundary;

  // A zero-length window is rejected outright and leaves the block untouched.
  assign start_ok  = bus.start && (bus.rollover_val != '0);
  assign start_bad = bus.start && (bus.rollover_val == '0);
  assign cnt_clear = bus.clear || start_ok;
  // A strobe coinciding with clear or an accepted start is dropped.
  assign cnt_en    = (state == RUN) && bus.cnt_up && !cnt_clear;
  assign boundary  = cnt_en && rollover_next;

  flex_counter #(
    .NUM_CNT_BITS (NUM_CNT_BITS)
  ) u_sample_cnt (
    .clk           (clk),
    .rst           (rst),
    .clear         (cnt_clear),
    .count_enable  (cnt_en),
    .rollover_val  (shadow_r),
    .count_out     (count),
    .rollover_flag (window_done),
    .rollover_next (rollover_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (bus.clear) begin
      state <= IDLE;
    end else if (start_ok) begin
      state <= RUN;
    end else if (boundary && !shadow_mode) begin
      state <= DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_r    <= '0;
      shadow_mode <= 1'b0;
    end else if (start_ok && !bus.clear) begin
      shadow_r    <= bus.rollover_val;
      shadow_mode <= bus.mode_cont;
    end
  end

  // Window count survives restarts; only clear or reset zero it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_cnt <= '0;
    end else if (bus.clear) begin
      window_cnt <= '0;
    end else if (boundary && (window_cnt != '1)) begin
      window_cnt <= window_cnt + NUM_WIN_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= start_bad && !bus.clear;
    end
  end

`ifdef FLEX_SAMPLE_CNT_IRQ_EN
  logic irq;

  // irq rises with window_done; a same-cycle ack loses to the new event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else if (bus.clear) begin
      irq <= 1'b0;
    end else if (boundary) begin
      irq <= 1'b1;
    end else if (bus.irq_ack) begin
      irq <= 1'b0;
    end
  end

  assign bus.irq = irq;
`endif

  assign bus.count_out   = count;
  assign bus.window_done = window_done;
  assign bus.window_cnt  = window_cnt;
  assign bus.busy        = (state == RUN);
  assign bus.cfg_err     = cfg_err;

endmodule

// File: tb/tb_flex_sample_counter.sv
// Scoreboard bench for flex_sample_counter: the driver queues hand-derived
// post-edge outputs, a monitor pops and compares them after every clock edge.
module tb_flex_sample_counter;

  localparam int CB = 10;
  localparam int WB = 2;

  typedef struct packed {
    logic [CB-1:0] c;
    logic          d;
    logic [WB-1:0] w;
    logic          b;
    logic          e;
    logic          irq;
  } exp_t;

  logic  tb_clk = 1'b0;
  logic  rst    = 1'b1;
  exp_t  exp_q[$];
  string nm_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 tb_clk = ~tb_clk;

  flex_sample_counter_if #(.NUM_CNT_BITS(CB), .NUM_WIN_BITS(WB)) bus ();

  flex_sample_counter #(
    .NUM_CNT_BITS (CB),
    .NUM_WIN_BITS (WB)
  ) dut (
    .clk (tb_clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic cyc(input string nm, input logic cl, input logic st, input logic md,
                     input logic [CB-1:0] rv, input logic cu, input logic ak,
                     input logic [CB-1:0] c, input logic d, input logic [WB-1:0] w,
                     input logic b, input logic e, input logic irq);
    exp_t x;
    @(negedge tb_clk);
    bus.clear        = cl;
    bus.start        = st;
    bus.mode_cont    = md;
    bus.rollover_val = rv;
    bus.cnt_up       = cu;
`ifdef FLEX_SAMPLE_CNT_IRQ_EN
    bus.irq_ack      = ak;
`endif
    x.c = c; x.d = d; x.w = w; x.b = b; x.e = e; x.irq = irq;
    if (ak === 1'bx) x.irq = irq;
    exp_q.push_back(x);
    nm_q.push_back(nm);
  endtask

  initial begin : monitor
    exp_t  x;
    string nm;
    forever begin
      @(posedge tb_clk);
      #2;
      if (exp_q.size() > 0) begin
        x  = exp_q.pop_front();
        nm = nm_q.pop_front();
        check({nm, ".count_out"},   32'(bus.count_out),   32'(x.c));
        check({nm, ".window_done"}, 32'(bus.window_done), 32'(x.d));
        check({nm, ".window_cnt"},  32'(bus.window_cnt),  32'(x.w));
        check({nm, ".busy"},        32'(bus.busy),        32'(x.b));
        check({nm, ".cfg_err"},     32'(bus.cfg_err),     32'(x.e));
`ifdef FLEX_SAMPLE_CNT_IRQ_EN
        check({nm, ".irq"},         32'(bus.irq),         32'(x.irq));
`endif
      end
    end
  end

  initial begin : driver
    bus.clear = 1'b0; bus.start = 1'b0; bus.mode_cont = 1'b0;
    bus.rollover_val = '0; bus.cnt_up = 1'b0;
`ifdef FLEX_SAMPLE_CNT_IRQ_EN
    bus.irq_ack = 1'b0;
`endif
    repeat (2) @(negedge tb_clk);
    rst = 1'b0;

    // Reset state, strobes ignored in IDLE
    cyc("por_idle",  0, 0, 0, 10'd0, 0, 0, 10'd0, 0, 2'd0, 0, 0, 0);
    cyc("por_strb",  0, 0, 0, 10'd0, 1, 0, 10'd0, 0, 2'd0, 0, 0, 0);

    // T1: async reset in the middle of a run at count 37
    cyc("t1_start",  0, 1, 1, 10'd100, 0, 0, 10'd0, 0, 2'd0, 1, 0, 0);
    for (int i = 1; i <= 37; i++)
      cyc("t1_strb", 0, 0, 1, 10'd100, 1, 0, CB'(i), 0, 2'd0, 1, 0, 0);
    @(posedge tb_clk);
    #3;
    rst = 1'b1;
    #1;
    check("t1_async.count_out",   32'(bus.count_out),   32'd0);
    check("t1_async.window_done", 32'(bus.window_done), 32'd0);
    check("t1_async.window_cnt",  32'(bus.window_cnt),  32'd0);
    check("t1_async.busy",        32'(bus.busy),        32'd0);
    check("t1_async.cfg_err",     32'(bus.cfg_err),     32'd0);
    bus.cnt_up = 1'b0; bus.start = 1'b0;
    @(negedge tb_clk);
    rst = 1'b0;
    cyc("t1_post1",  0, 0, 1, 10'd100, 1, 0, 10'd0, 0, 2'd0, 0, 0, 0);
    cyc("t1_post2",  0, 0, 1, 10'd100, 1, 0, 10'd0, 0, 2'd0, 0, 0, 0);

    // T2: one-shot R=1000; rollover_val wiggles after start and must be ignored
    cyc("t2_start",  0, 1, 0, 10'd1000, 0, 0, 10'd0, 0, 2'd0, 1, 0, 0);
    for (int i = 1; i <= 1000; i++)
      cyc("t2_strb", 0, 0, 0, 10'd3, 1, 0, CB'(i), (i == 1000), (i == 1000) ? 2'd1 : 2'd0,
          (i != 1000), 0, (i == 1000));
    cyc("t2_extra",  0, 0, 0, 10'd3, 1, 0, 10'd1000, 0, 2'd1, 0, 0, 1);

    // T3: continuous R=4, nine strobes
    cyc("t3_clear",  1, 0, 0, 10'd0, 0, 0, 10'd0, 0, 2'd0, 0, 0, 0);
    cyc("t3_start",  0, 1, 1, 10'd4, 0, 0, 10'd0, 0, 2'd0, 1, 0, 0);
    for (int i = 1; i <= 9; i++)
      cyc("t3_strb", 0, 0, 0, 10'd7, 1, 0, CB'((i - 1) % 4 + 1), (i % 4 == 0),
          (i >= 8) ? 2'd2 : (i >= 4) ? 2'd1 : 2'd0, 1, 0, (i >= 4));

    // T4: rejected start, clear vs start, start vs strobe
    cyc("t4_clear",  1, 0, 0, 10'd0, 0, 0, 10'd0, 0, 2'd0, 0, 0, 0);
    cyc("t4_r0",     0, 1, 1, 10'd0, 0, 0, 10'd0, 0, 2'd0, 0, 1, 0);
    cyc("t4_r0_nxt", 0, 0, 0, 10'd0, 1, 0, 10'd0, 0, 2'd0, 0, 0, 0);
    cyc("t4_run",    0, 1, 1, 10'd10, 0, 0, 10'd0, 0, 2'd0, 1, 0, 0);
    cyc("t4_s1",     0, 0, 1, 10'd10, 1, 0, 10'd1, 0, 2'd0, 1, 0, 0);
    cyc("t4_s2",     0, 0, 1, 10'd10, 1, 0, 10'd2, 0, 2'd0, 1, 0, 0);
    cyc("t4_clr_st", 1, 1, 1, 10'd10, 0, 0, 10'd0, 0, 2'd0, 0, 0, 0);
    cyc("t4_idle",   0, 0, 1, 10'd10, 1, 0, 10'd0, 0, 2'd0, 0, 0, 0);
    cyc("t4_run2",   0, 1, 1, 10'd10, 0, 0, 10'd0, 0, 2'd0, 1, 0, 0);
    for (int i = 1; i <= 3; i++)
      cyc("t4_strb", 0, 0, 1, 10'd10, 1, 0, CB'(i), 0, 2'd0, 1, 0, 0);
    cyc("t4_st_cu",  0, 1, 1, 10'd10, 1, 0, 10'd0, 0, 2'd0, 1, 0, 0);
    cyc("t4_after",  0, 0, 1, 10'd10, 1, 0, 10'd1, 0, 2'd0, 1, 0, 0);

    // T5: R=1 continuous, window counter saturates at 3, retained across start
    cyc("t5_clear",  1, 0, 0, 10'd0, 0, 0, 10'd0, 0, 2'd0, 0, 0, 0);
    cyc("t5_start",  0, 1, 1, 10'd1, 0, 0, 10'd0, 0, 2'd0, 1, 0, 0);
    for (int i = 1; i <= 6; i++)
      cyc("t5_strb", 0, 0, 1, 10'd1, 1, 0, 10'd1, 1, (i >= 3) ? 2'd3 : WB'(i), 1, 0, 1);
    cyc("t5_restart", 0, 1, 1, 10'd1, 0, 0, 10'd0, 0, 2'd3, 1, 0, 1);

`ifdef FLEX_SAMPLE_CNT_IRQ_EN
    // T6: sticky irq, ack, and ack losing to a same-cycle boundary
    cyc("t6_clear",  1, 0, 0, 10'd0, 0, 0, 10'd0, 0, 2'd0, 0, 0, 0);
    cyc("t6_start",  0, 1, 1, 10'd2, 0, 0, 10'd0, 0, 2'd0, 1, 0, 0);
    cyc("t6_s1",     0, 0, 1, 10'd2, 1, 0, 10'd1, 0, 2'd0, 1, 0, 0);
    cyc("t6_s2",     0, 0, 1, 10'd2, 1, 0, 10'd2, 1, 2'd1, 1, 0, 1);
    cyc("t6_hold",   0, 0, 1, 10'd2, 0, 0, 10'd2, 0, 2'd1, 1, 0, 1);
    cyc("t6_ack",    0, 0, 1, 10'd2, 0, 1, 10'd2, 0, 2'd1, 1, 0, 0);
    cyc("t6_s3",     0, 0, 1, 10'd2, 1, 0, 10'd1, 0, 2'd1, 1, 0, 0);
    cyc("t6_s4_ack", 0, 0, 1, 10'd2, 1, 1, 10'd2, 1, 2'd2, 1, 0, 1);
    cyc("t6_held",   0, 0, 1, 10'd2, 0, 0, 10'd2, 0, 2'd2, 1, 0, 1);
`endif

    cyc("end_idle",  0, 0, 1, 10'd2, 0, 0, 10'd0, 0, 2'd0, 0, 0, 0);
    exp_q.pop_back();
    nm_q.pop_back();
    @(posedge tb_clk);
    #3;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
